alu_exec_unit: RTL
==================

# alu_exec_unit

Parametrised successor to the single-cycle ALU control path: decodes ALUOp/funct3/funct7 and executes the operation, including multi-cycle RISC-V M-extension multiply and divide. It sits in the EX stage of the multi-cycle CPU. The control FSM drives it through a valid/ready handshake and holds in EX until `out_valid`. Base integer ops complete in one cycle; MUL*/DIV*/REM* iterate one bit per cycle.

## Interface
- `XLEN`, 32, datapath width; power of two, ≥ 8
- `SHAMT_W`, $clog2(XLEN), shift-amount bits taken from operand 2
- `clk` input 1: sole clock, rising edge
- `reset` input 1: synchronous, active-low
- `in_valid` input 1: operation request
- `in_ready` output 1: unit can accept; high only in IDLE
- `ALUOp` input 2: 00 add, 01 branch, 10 R-type, 11 I-type arithmetic
- `funct3` input 3: instruction funct3
- `funct7` input 7: full instruction funct7
- `alu_in_1` input XLEN: rs1 operand
- `alu_in_2` input XLEN: rs2 or immediate operand
- `out_valid` output 1: result available; held until `out_ready`
- `out_ready` input 1: consumer takes result
- `alu_result` output XLEN: result
- `bcond` output 1: branch taken (ALUOp 01 only, else 0)
- `illegal` output 1: qualifies `out_valid`; decode hit no legal op

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- Request is accepted when `in_valid && in_ready`. Operands and decoded op are latched.
- IDLE with a base op: compute, register the result, and go to DONE.
- IDLE with MUL/MULH/MULHSU/MULHU: go to MUL. Shift-add runs over 2·XLEN product bits, one operand bit per cycle, for XLEN cycles. Signed variants negate magnitudes and fix the sign at the end.
- IDLE with DIV/DIVU/REM/REMU: go to DIV. Restoring division, one quotient bit per cycle, XLEN cycles.
- MUL/DIV go to DONE after the last iteration.
- DONE holds `alu_result`/`bcond`/`illegal` stable until `out_ready`, then goes to IDLE.
- Decode for ALUOp 00: ADD.
- Decode for ALUOp 01: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - `bcond` is set from the compare; `alu_result` = in_1 − in_2.
  - funct3 010/011 → illegal.
- Decode for ALUOp 10:
  - funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 0100000: SUB (f3 000), SRA (f3 101).
  - funct7 0000001: M-extension.
  - Any other funct7 → illegal.
- Decode for ALUOp 11: as 10 without SUB and M.
  - funct7 is examined only for f3 001/101 (SLLI/SRLI/SRAI).
- Shifts use `alu_in_2[SHAMT_W-1:0]` only.
- Divide special cases resolve in IDLE→DONE (1 cycle):
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed MIN ÷ −1: quotient MIN, remainder 0.
- Illegal op: goes to DONE in 1 cycle with `alu_result`=0, `bcond`=0, `illegal`=1.

## Timing
- Reset: state IDLE; `out_valid`=0, `alu_result`=0, `bcond`=0, `illegal`=0; `in_ready`=1 on the first cycle after reset.
- Reset asserted mid-MUL/DIV aborts the operation with no result produced.
- Base op: accepted at edge N; `out_valid` high after edge N+1.
- MUL/DIV: `out_valid` high after edge N+XLEN+1.
- `out_valid && out_ready` at edge M → IDLE, `in_ready`=1 after M.
- There is no back-to-back acceptance in the DONE cycle.
- `in_valid` while busy is ignored; the requester must hold its request.
- `out_ready` outside DONE has no effect.

## Configuration
- `ALU_MULDIV_EN` defined: MUL and DIV states, iteration counter and datapath are compiled in.
- `ALU_MULDIV_EN` undefined: funct7 0000001 with ALUOp 10 decodes as illegal, and the FSM uses IDLE/DONE only.
- All other behaviour is identical in both builds.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` enum (ADD…REMU, BEQ…BGEU, ILLEGAL)
  - `alu_state_t` enum
  - funct3/funct7 constants, including `FUNCT7_MULDIV` = 7'b0000001
- Sub-module `alu_op_decode`: combinational ALUOp/funct3/funct7 → `alu_op_t`. It is instantiated once and is unit-testable alone.
- Iteration counter width: $clog2(XLEN)+1.

## Test plan
- Reset low 2 cycles, then high → `in_ready`=1, `out_valid`=0, `alu_result`=0.
- ALUOp 10, f7 0100000, f3 101, in_1 0x80000000, in_2 0x00000024 → 0xF8000000 one cycle after accept (shamt 4).
- ALUOp 01, BLTU, in_1 1, in_2 0xFFFFFFFF → `bcond`=1. BLT with the same operands → `bcond`=0.
- MULH, 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF at accept+33. MULHU with the same operands → 0x00000001.
- DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000 at accept+1. REMU 7 ÷ 0 → 7. DIVU 100 ÷ 7 → 14 at accept+33.
- `out_ready` held low 5 cycles in DONE → result stable and `in_ready`=0. Reset during DIV cycle 10 → IDLE, no `out_valid`. Without `ALU_MULDIV_EN`, MUL → `illegal`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and encodings for the EX-stage ALU: operation codes, FSM states
// and the funct3/funct7 constants used by the decoder.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_ILLEGAL
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_t;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic alu_op_t base_op(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return OP_ADD;
      F3_SLL:  return OP_SLL;
      F3_SLT:  return OP_SLT;
      F3_SLTU: return OP_SLTU;
      F3_XOR:  return OP_XOR;
      F3_SR:   return OP_SRL;
      F3_OR:   return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct3/funct7 -> alu_op_t decoder.
// M-extension decode is present only when ALU_MULDIV_EN is defined.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    op
);

  always_comb begin
    op = OP_ILLEGAL;
    case (ALUOp)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_ILLEGAL;
        endcase
      end
      ALUOP_RTYPE: begin
        if (funct7 == FUNCT7_BASE) begin
          op = base_op(funct3);
        end else if (funct7 == FUNCT7_ALT) begin
          if (funct3 == F3_ADD)     op = OP_SUB;
          else if (funct3 == F3_SR) op = OP_SRA;
        end
`ifdef ALU_MULDIV_EN
        else if (funct7 == FUNCT7_MULDIV) begin
          case (funct3)
            3'b000:  op = OP_MUL;
            3'b001:  op = OP_MULH;
            3'b010:  op = OP_MULHSU;
            3'b011:  op = OP_MULHU;
            3'b100:  op = OP_DIV;
            3'b101:  op = OP_DIVU;
            3'b110:  op = OP_REM;
            default: op = OP_REMU;
          endcase
        end
`endif
      end
      default: begin
        // Immediate forms: funct7 only qualifies the shift encodings
        if (funct3 == F3_SLL) begin
          op = (funct7 == FUNCT7_BASE) ? OP_SLL : OP_ILLEGAL;
        end else if (funct3 == F3_SR) begin
          if (funct7 == FUNCT7_BASE)     op = OP_SRL;
          else if (funct7 == FUNCT7_ALT) op = OP_SRA;
        end else begin
          op = base_op(funct3);
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready handshake; base ops finish in one cycle,
// iterative multiply/divide is compiled in with ALU_MULDIV_EN.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] alu_in_1,
  input  logic [XLEN-1:0] alu_in_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            bcond,
  output logic            illegal
);

  alu_state_t      state_q;
  logic [XLEN-1:0] result_q;
  logic            bcond_q, illegal_q;
  alu_op_t         op;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0] base_res;
  logic            base_bcond;

  alu_op_decode u_decode (.ALUOp(ALUOp), .funct3(funct3), .funct7(funct7), .op(op));

  assign shamt      = alu_in_2[SHAMT_W-1:0];
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign alu_result = result_q;
  assign bcond      = bcond_q;
  assign illegal    = illegal_q;

  always_comb begin
    base_res   = '0;
    base_bcond = 1'b0;
    case (op)
      OP_ADD:  base_res = alu_in_1 + alu_in_2;
      OP_SUB:  base_res = alu_in_1 - alu_in_2;
      OP_SLL:  base_res = alu_in_1 << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(alu_in_1) < $signed(alu_in_2)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, alu_in_1 < alu_in_2};
      OP_XOR:  base_res = alu_in_1 ^ alu_in_2;
      OP_SRL:  base_res = alu_in_1 >> shamt;
      OP_SRA:  base_res = $signed(alu_in_1) >>> shamt;
      OP_OR:   base_res = alu_in_1 | alu_in_2;
      OP_AND:  base_res = alu_in_1 & alu_in_2;
      OP_BEQ:  begin base_res = alu_in_1 - alu_in_2; base_bcond = (alu_in_1 == alu_in_2); end
      OP_BNE:  begin base_res = alu_in_1 - alu_in_2; base_bcond = (alu_in_1 != alu_in_2); end
      OP_BLT:  begin base_res = alu_in_1 - alu_in_2; base_bcond = ($signed(alu_in_1) < $signed(alu_in_2)); end
      OP_BGE:  begin base_res = alu_in_1 - alu_in_2; base_bcond = ($signed(alu_in_1) >= $signed(alu_in_2)); end
      OP_BLTU: begin base_res = alu_in_1 - alu_in_2; base_bcond = (alu_in_1 < alu_in_2); end
      OP_BGEU: begin base_res = alu_in_1 - alu_in_2; base_bcond = (alu_in_1 >= alu_in_2); end
      default: ;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, mcand_q, acc_d, prod_d;
  logic [XLEN-1:0]   shreg_q, divisor_q, rem_q;
  logic [XLEN-1:0]   quo_d, rem_d, mul_res, div_res, a_mag, b_mag, special_res;
  logic [XLEN:0]     trial;
  logic              neg_q, rem_neg_q, sel_q;
  logic              is_mul, is_div, is_rem, a_neg, b_neg, div_zero, div_ovf, ge, last_iter;

  always_comb begin
    is_mul   = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    is_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_rem   = op inside {OP_REM, OP_REMU};
    a_neg    = (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && alu_in_1[XLEN-1];
    b_neg    = (op inside {OP_MULH, OP_DIV, OP_REM}) && alu_in_2[XLEN-1];
    a_mag    = a_neg ? -alu_in_1 : alu_in_1;
    b_mag    = b_neg ? -alu_in_2 : alu_in_2;
    div_zero = (alu_in_2 == '0);
    div_ovf  = (op inside {OP_DIV, OP_REM}) && (alu_in_1 == MIN_VAL) && (alu_in_2 == '1);
    special_res = is_rem ? (div_zero ? alu_in_1 : '0) : (div_zero ? '1 : MIN_VAL);
    last_iter = (cnt_q == CNT_W'(XLEN - 1));
    // Multiply: accumulate the shifted multiplicand for each set multiplier bit
    acc_d   = acc_q + (shreg_q[0] ? mcand_q : '0);
    prod_d  = neg_q ? -acc_d : acc_d;
    mul_res = sel_q ? prod_d[2*XLEN-1:XLEN] : prod_d[XLEN-1:0];
    // Divide: shift the next dividend bit into the partial remainder and trial-subtract
    trial   = {rem_q, shreg_q[XLEN-1]};
    ge      = (trial >= {1'b0, divisor_q});
    rem_d   = ge ? (trial[XLEN-1:0] - divisor_q) : trial[XLEN-1:0];
    quo_d   = {shreg_q[XLEN-2:0], ge};
    div_res = sel_q ? (rem_neg_q ? -rem_d : rem_d) : (neg_q ? -quo_d : quo_d);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      bcond_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          bcond_q   <= 1'b0;
          illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
          cnt_q <= '0;
          if (is_mul) begin
            acc_q   <= '0;
            mcand_q <= {{XLEN{1'b0}}, a_mag};
            shreg_q <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            sel_q   <= (op != OP_MUL);
            state_q <= MUL;
          end else if (is_div && (div_zero || div_ovf)) begin
            result_q <= special_res;
            state_q  <= DONE;
          end else if (is_div) begin
            rem_q     <= '0;
            shreg_q   <= a_mag;
            divisor_q <= b_mag;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            sel_q     <= is_rem;
            state_q   <= DIV;
          end else
`endif
          begin
            result_q  <= base_res;
            bcond_q   <= base_bcond;
            illegal_q <= (op == OP_ILLEGAL);
            state_q   <= DONE;
          end
        end
`ifdef ALU_MULDIV_EN
        MUL: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          shreg_q <= shreg_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            result_q <= mul_res;
            state_q  <= DONE;
          end
        end
        DIV: begin
          rem_q   <= rem_d;
          shreg_q <= quo_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            result_q <= div_res;
            state_q  <= DONE;
          end
        end
`endif
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
